// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, mux selects and AluOP from the current state.
module multicycle_main_control #(
   parameter int OPW  = 6,
   parameter int AOPW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            branch_ne,
   output logic            iord,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      pc_source,
   output logic [AOPW-1:0] alu_op,
   output logic            illegal_op,
   output logic [3:0]      state_o
);

   localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
   localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
   localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
   localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);

   localparam logic [AOPW-1:0] AOP_ADD  = AOPW'(3'b000);
   localparam logic [AOPW-1:0] AOP_SUB  = AOPW'(3'b001);
   localparam logic [AOPW-1:0] AOP_RT   = AOPW'(3'b010);
   localparam logic [AOPW-1:0] AOP_ANDI = AOPW'(3'b100);
   localparam logic [AOPW-1:0] AOP_ORI  = AOPW'(3'b101);
   localparam logic [AOPW-1:0] AOP_SLTI = AOPW'(3'b110);
   localparam logic [AOPW-1:0] AOP_LUI  = AOPW'(3'b111);

   typedef enum logic [3:0] {
      S_IDLE     = 4'h0,
      S_FETCH    = 4'h1,
      S_DECODE   = 4'h2,
      S_MEM_ADDR = 4'h3,
      S_MEM_RD   = 4'h4,
      S_MEM_WR   = 4'h5,
      S_MEM_WB   = 4'h6,
      S_R_EXEC   = 4'h7,
      S_R_WB     = 4'h8,
      S_I_EXEC   = 4'h9,
      S_I_WB     = 4'hA,
      S_BRANCH   = 4'hB,
      S_JUMP     = 4'hC
   } state_t;

   typedef struct packed {
      logic            pc_write;
      logic            pc_write_cond;
      logic            branch_ne;
      logic            iord;
      logic            mem_read;
      logic            mem_write;
      logic            ir_write;
      logic            reg_dst;
      logic            mem_to_reg;
      logic            reg_write;
      logic            alu_src_a;
      logic [1:0]      alu_src_b;
      logic [1:0]      pc_source;
      logic [AOPW-1:0] alu_op;
      logic            illegal_op;
   } ctrl_t;

   state_t state, state_nxt;
   ctrl_t  ctrl;
   logic   br_ne_q;

   // The branch sense is captured at decode so later opcode changes cannot leak in.
   logic unused_zero;
   assign unused_zero = zero;

   function automatic state_t decode_target(input logic [OPW-1:0] op);
      state_t t;
      case (op)
         OP_RTYPE:                                  t = S_R_EXEC;
         OP_LW, OP_SW:                              t = S_MEM_ADDR;
         OP_BEQ, OP_BNE:                            t = S_BRANCH;
         OP_J:                                      t = S_JUMP;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: t = S_I_EXEC;
         default:                                   t = S_FETCH;
      endcase
      return t;
   endfunction

   function automatic logic [AOPW-1:0] i_alu_op(input logic [OPW-1:0] op);
      logic [AOPW-1:0] a;
      case (op)
         OP_ANDI: a = AOP_ANDI;
         OP_ORI:  a = AOP_ORI;
         OP_SLTI: a = AOP_SLTI;
         OP_LUI:  a = AOP_LUI;
         default: a = AOP_ADD;
      endcase
      return a;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  br_ne_q <= 1'b0;
      else if (state == S_DECODE)  br_ne_q <= opcode[0];
   end

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_IDLE:     state_nxt = S_FETCH;
         S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_nxt = decode_target(opcode);
         S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
         S_MEM_WB:   state_nxt = S_FETCH;
         S_R_EXEC:   state_nxt = S_R_WB;
         S_R_WB:     state_nxt = S_FETCH;
         S_I_EXEC:   state_nxt = S_I_WB;
         S_I_WB:     state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JUMP:     state_nxt = S_FETCH;
         default:    state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = 2'b11;
            ctrl.illegal_op = (decode_target(opcode) == S_FETCH);
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = AOP_RT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op    = i_alu_op(opcode);
         end
         S_I_WB: ctrl.reg_write = 1'b1;
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = AOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            ctrl.branch_ne     = br_ne_q;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
         end
         default: ctrl = '0;
      endcase
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign branch_ne     = ctrl.branch_ne;
   assign iord          = ctrl.iord;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign pc_source     = ctrl.pc_source;
   assign alu_op        = ctrl.alu_op;
   assign illegal_op    = ctrl.illegal_op;
   assign state_o       = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench: an instruction-level timeline drives the FSM and a field-wise
// model of each phase's controls is compared against the DUT every cycle.
module tb_multicycle_main_control;

   localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_MADDR = 3, P_MRD = 4,
                  P_MWR = 5, P_MWB = 6, P_REX = 7, P_RWB = 8, P_IEX = 9,
                  P_IWB = 10, P_BR = 11, P_JMP = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
   logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [3:0] state_o;

   multicycle_main_control #(.OPW(6), .AOPW(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
   );

   always #5 clk = ~clk;

   logic [18:0] dut_ctrl;
   assign dut_ctrl = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                      ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                      pc_source, alu_op, illegal_op};

   int         total = 0;
   int         bad = 0;
   int         exp_ph = P_IDLE;
   logic       chk_en = 1'b0;
   logic [5:0] cur_op = '0;
   int         code_of [13];
   int         ph_of_code [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic known_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                        6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                        6'b001111};
   endfunction

   // Each control line is expressed as the set of phases in which it is active.
   function automatic logic [18:0] model(input int ph, input logic [5:0] op, input logic rdy);
      logic pcw, pcwc, bne, io, mrd, mwr, irw, rdst, m2r, rw, asa, ill;
      logic [1:0] asb, pcs;
      logic [2:0] aop;
      pcw  = (ph == P_FETCH && rdy) || ph == P_JMP;
      pcwc = (ph == P_BR);
      bne  = (ph == P_BR) && op[0];
      io   = (ph == P_MRD) || (ph == P_MWR);
      mrd  = (ph == P_FETCH) || (ph == P_MRD);
      mwr  = (ph == P_MWR);
      irw  = (ph == P_FETCH) && rdy;
      rdst = (ph == P_RWB);
      m2r  = (ph == P_MWB);
      rw   = (ph == P_MWB) || (ph == P_RWB) || (ph == P_IWB);
      asa  = (ph == P_MADDR) || (ph == P_REX) || (ph == P_IEX) || (ph == P_BR);
      asb  = (ph == P_FETCH) ? 2'd1 : (ph == P_DEC) ? 2'd3 :
             (ph == P_MADDR || ph == P_IEX) ? 2'd2 : 2'd0;
      pcs  = (ph == P_BR) ? 2'd1 : (ph == P_JMP) ? 2'd2 : 2'd0;
      aop  = 3'd0;
      if (ph == P_REX) aop = 3'd2;
      if (ph == P_BR)  aop = 3'd1;
      if (ph == P_IEX)
         aop = (op == 6'b001100) ? 3'd4 : (op == 6'b001101) ? 3'd5 :
               (op == 6'b001010) ? 3'd6 : (op == 6'b001111) ? 3'd7 : 3'd0;
      ill  = (ph == P_DEC) && !known_op(op);
      return {pcw, pcwc, bne, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, aop, ill};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check($sformatf("ctrl_ph%0d_op%02h", exp_ph, cur_op), 32'(dut_ctrl),
               32'(model(exp_ph, cur_op, mem_ready)));
         check("mem_rw_excl", 32'(mem_read & mem_write), 32'd0);
         check("aop_not_011", 32'(alu_op == 3'b011), 32'd0);
         // state_o must map each phase to one stable, unique code
         if (code_of[exp_ph] >= 0)
            check($sformatf("state_code_ph%0d", exp_ph), 32'(state_o), 32'(code_of[exp_ph]));
         else begin
            check($sformatf("state_code_unique_ph%0d", exp_ph),
                  32'(ph_of_code[state_o] + 1), 32'd0);
            code_of[exp_ph] = int'(state_o);
            ph_of_code[state_o] = exp_ph;
         end
         if (exp_ph == P_REX) check("rexec_aop", 32'(alu_op), 32'h2);
         if (exp_ph == P_RWB) check("rwb_we_dst", 32'({reg_write, reg_dst}), 32'h3);
         if (exp_ph == P_BR)  check("br_aop_ne", 32'({alu_op, branch_ne}), 32'({3'b001, cur_op[0]}));
         if (exp_ph == P_IEX && cur_op == 6'b001101) check("ori_aop", 32'(alu_op), 32'h5);
         if (exp_ph == P_DEC && cur_op == 6'b111111) check("ill_pulse", 32'(illegal_op), 32'h1);
         if (exp_ph == P_FETCH && cur_op == 6'b111111) check("ill_clear", 32'(illegal_op), 32'h0);
      end
   end

   function automatic logic [5:0] junk();
      return 6'($urandom);
   endfunction

   function automatic logic rnd1();
      return 1'($urandom);
   endfunction

   task automatic step(input int ph, input logic rdy, input logic [5:0] drv_op);
      mem_ready = rdy;
      opcode    = drv_op;
      zero      = rnd1();
      exp_ph    = ph;
      chk_en    = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [5:0] op, input int fw, input int mw);
      cur_op = op;
      for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, junk());
      step(P_FETCH, 1'b1, junk());
      step(P_DEC, rnd1(), op);
      case (op)
         6'b000000: begin
            step(P_REX, rnd1(), junk());
            step(P_RWB, rnd1(), junk());
         end
         6'b100011: begin
            step(P_MADDR, rnd1(), op);
            for (int i = 0; i < mw; i++) step(P_MRD, 1'b0, junk());
            step(P_MRD, 1'b1, junk());
            step(P_MWB, rnd1(), junk());
         end
         6'b101011: begin
            step(P_MADDR, rnd1(), op);
            for (int i = 0; i < mw; i++) step(P_MWR, 1'b0, junk());
            step(P_MWR, 1'b1, junk());
         end
         6'b000100, 6'b000101: step(P_BR, rnd1(), junk());
         6'b000010:            step(P_JMP, rnd1(), junk());
         6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: begin
            step(P_IEX, rnd1(), op);
            step(P_IWB, rnd1(), junk());
         end
         default: ;
      endcase
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 13; i++) code_of[i] = -1;
      for (int i = 0; i < 16; i++) ph_of_code[i] = -1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", 32'(dut_ctrl), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      rst_n = 1'b1;
      step(P_IDLE, 1'b1, junk());

      run(6'b000000, 0, 0);
      run(6'b100011, 0, 3);
      run(6'b101011, 1, 2);
      run(6'b000100, 0, 0);
      run(6'b000101, 0, 0);
      run(6'b001000, 0, 0);
      run(6'b001100, 0, 0);
      run(6'b001101, 0, 0);
      run(6'b001010, 0, 0);
      run(6'b001111, 0, 0);
      run(6'b111111, 0, 0);
      run(6'b000001, 0, 0);
      run(6'b000000, 2, 0);
      run(6'b000010, 0, 0);
      run(6'b100011, 1, 0);

      // Abort a stalled store with an asynchronous reset.
      cur_op = 6'b101011;
      step(P_FETCH, 1'b1, junk());
      step(P_DEC, 1'b1, cur_op);
      step(P_MADDR, 1'b1, cur_op);
      step(P_MWR, 1'b0, junk());
      step(P_MWR, 1'b0, junk());
      chk_en    = 1'b0;
      mem_ready = 1'b0;
      #2;
      check("pre_rst_mem_write", 32'(mem_write), 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_rst_mem_write", 32'(mem_write), 32'h0);
      check("async_rst_ctrl", 32'(dut_ctrl), 32'd0);
      mem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("held_rst_ctrl", 32'(dut_ctrl), 32'd0);
      rst_n = 1'b1;
      step(P_IDLE, 1'b1, junk());
      run(6'b000000, 0, 0);
      step(P_FETCH, 1'b0, junk());
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the CPU datapath.
- Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and writeback over several clocks.
- Generates the datapath enables, mux selects and the 3-bit AluOP that the ALU control decoder consumes alongside Func.
- Stalls on a variable-latency memory through a ready handshake.

Parameters:
- OPW, 6, opcode width.
- AOPW, 3, AluOP width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  conditional PC load (branch)
- branch_ne  output  1  1 = take branch on !zero, 0 = on zero
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- reg_dst  output  1  destination: 1 = rd, 0 = rt
- mem_to_reg  output  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- pc_source  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  output  3  AluOP to the ALU control decoder
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- state_o  output  4  current state, for debug

Behaviour:
- Reset (rst_n = 0, async): state = IDLE. All outputs 0, including alu_op = 000.
- Reset mid-access aborts immediately. No write completes after reset assertion.
- Outputs are decoded from the current state (Moore), except that ir_write and pc_write in FETCH are gated by mem_ready.
- AluOP encoding:
  - 000 = add (address/PC increment).
  - 001 = sub (branch compare).
  - 010 = R-type; the operation comes from Func.
  - 100 = andi, 101 = ori, 110 = slti, 111 = lui-class.
  - 011 is never driven.
- States and transitions:
  - IDLE: all outputs 0. Next state FETCH.
  - FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 00.
    - mem_ready = 0: stay in FETCH; ir_write = pc_write = 0.
    - mem_ready = 1: ir_write = 1, pc_write = 1, next DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 000. Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 or 000101 -> BRANCH
    - 000010 -> JUMP
    - 001000, 001100, 001101, 001010, 001111 -> I_EXEC
    - any other opcode -> FETCH, with illegal_op = 1 for this cycle only.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_read = 1, iord = 1. Hold until mem_ready, then MEM_WB.
  - MEM_WR: mem_write = 1, iord = 1. Hold until mem_ready, then FETCH.
  - MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next FETCH.
  - R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 010. Next R_WB.
  - R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next FETCH.
  - I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op per opcode:
    - addi 000, andi 100, ori 101, slti 110, lui 111.
    - Next I_WB.
  - I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_write_cond = 1, pc_source = 01, branch_ne = opcode[0]. Next FETCH. The PC load decision belongs to the datapath.
  - JUMP: pc_write = 1, pc_source = 10. Next FETCH.
- Opcode is sampled only in DECODE and MEM_ADDR/I_EXEC; changes in other states are ignored.
- Memory handshake:
  - The request is held stable while mem_ready = 0.
  - mem_ready is ignored in states without a request.
- Exactly one of mem_read / mem_write may be high in any cycle; never both.
- Cycle counts with mem_ready tied high:
  - R-type 4, lw 5, sw 4, branch 3, jump 3, I-type 4.
  - The first instruction after reset takes one extra cycle (IDLE).
- No unreachable state may lock up. State encodings 4'hD–4'hF go to FETCH.

Test Plan:
- Reset, then release with mem_ready = 1 and opcode 000000: states IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH. alu_op = 010 in R_EXEC; reg_write = reg_dst = 1 in R_WB.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD: mem_read and iord held for 4 cycles, then MEM_WB with reg_write = 1, mem_to_reg = 1. Total 8 cycles from FETCH.
- sw (101011) and beq/bne (000100/000101):
  - sw: mem_write = 1 only in MEM_WR, mem_read never high.
  - beq: alu_op = 001, branch_ne = 0. bne: branch_ne = 1.
- I-type sweep (addi, andi, ori, slti, lui): alu_op in I_EXEC equals 000, 100, 101, 110, 111 respectively. alu_op never equals 011 in any state.
- Illegal opcode 111111 in DECODE: illegal_op pulses for 1 cycle, next state FETCH, no reg_write or mem_write asserted.
- Assert rst_n low during MEM_WR with mem_ready = 0: mem_write drops asynchronously. After release the FSM passes through IDLE, then FETCH.
